// File: rtl/spi_master_multi.sv
// SPI master with runtime word length, clock divider, CPOL/CPHA, bit order,
// NUM_CS chip selects and abort. Configuration is frozen when a start is accepted.
module spi_master_multi #(
    parameter int DATA_W = 32,
    parameter int NUM_CS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       ctrl,
    input  logic [DATA_W-1:0] data_tx,
    output logic [DATA_W-1:0] data_rd,
    output logic              busy,
    output logic              done,
    input  logic              spi_i,
    output logic              spi_clk,
    output logic [NUM_CS-1:0] cs_n,
    output logic              spi_o
);
    localparam int NBW = $clog2(DATA_W + 1);
    localparam int EW  = NBW + 1;
    localparam logic [8:0]     NUM_CS_L = 9'(NUM_CS);
    localparam logic [6:0]     DATA_W_L = 7'(DATA_W);
    localparam logic [NBW-1:0] NB_ONE   = {{(NBW-1){1'b0}}, 1'b1};
    localparam logic [EW-1:0]  EDGE_ONE = {{(EW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        XFER  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t            state_r, state_nxt_s;
    logic              start_q_r, abort_q_r;
    logic              cpol_r, cpha_r, lsb_r;
    logic [7:0]        div_r, div_cnt_r;
    logic [NBW-1:0]    nbits_r;
    logic [EW-1:0]     edge_cnt_r;
    logic [DATA_W-1:0] tx_shift_r, rx_r, data_rd_r;
    logic              busy_r, done_r, spi_clk_r, spi_o_r;
    logic [NUM_CS-1:0] cs_n_r;

    logic [7:0]        div_s;
    logic [NBW-1:0]    nbits_s;
    logic [DATA_W-1:0] src_s, tx_next_s, rx_next_s;
    logic [NUM_CS-1:0] cs_mask_s;
    logic              first_bit_s, next_bit_s, cs_ok_s;
    logic              start_edge_s, abort_edge_s, tick_s, accept_s, abort_s;
    logic              edge_s, finish_s, leading_s, sample_s, shift_s, last_edge_s;
    logic              ctrl_unused_s;

    assign ctrl_unused_s = &{1'b0, ctrl[7:5], ctrl[30]};

    // Decode the live ctrl word into the configuration a start would latch.
    always_comb begin
        if (ctrl[15:8] == 8'd0) begin
            div_s = 8'd1;
        end else begin
            div_s = ctrl[15:8];
        end
        if ((ctrl[29:24] == 6'd0) || ({1'b0, ctrl[29:24]} > DATA_W_L)) begin
            nbits_s = NBW'(DATA_W);
        end else begin
            nbits_s = NBW'(ctrl[29:24]);
        end
        // A load in the start cycle wins over the previously loaded word.
        if (ctrl[0]) begin
            src_s = data_tx;
        end else begin
            src_s = tx_shift_r;
        end
        if (ctrl[4]) begin
            first_bit_s = src_s[0];
        end else begin
            first_bit_s = |(src_s & (DATA_W'(1'b1) << (nbits_s - NB_ONE)));
        end
        cs_ok_s   = ({1'b0, ctrl[23:16]} < NUM_CS_L);
        cs_mask_s = NUM_CS'(1'b1) << ctrl[23:16];
    end

    // Edge detection, event decode and next-state logic.
    always_comb begin
        start_edge_s = ctrl[1] & ~start_q_r;
        abort_edge_s = ctrl[31] & ~abort_q_r;
        tick_s       = (div_cnt_r == 8'd0);
        accept_s     = (state_r == IDLE) & start_edge_s & ~abort_edge_s & cs_ok_s;
        abort_s      = (state_r != IDLE) & abort_edge_s;
        edge_s       = ((state_r == SETUP) | (state_r == XFER)) & tick_s & ~abort_s;
        finish_s     = (state_r == HOLD) & tick_s & ~abort_s;
        leading_s    = ~edge_cnt_r[0];
        sample_s     = edge_s & (leading_s ^ cpha_r);
        // With CPHA=1 the first leading edge re-drives the bit already set up.
        if (cpha_r) begin
            shift_s = edge_s & leading_s & (edge_cnt_r != {EW{1'b0}});
        end else begin
            shift_s = edge_s & ~leading_s;
        end
        last_edge_s  = ((edge_cnt_r + EDGE_ONE) == {nbits_r, 1'b0});
        state_nxt_s  = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = SETUP;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SETUP: begin
                if (abort_s) begin
                    state_nxt_s = IDLE;
                end else if (edge_s) begin
                    state_nxt_s = XFER;
                end else begin
                    state_nxt_s = SETUP;
                end
            end
            XFER: begin
                if (abort_s) begin
                    state_nxt_s = IDLE;
                end else if (edge_s && last_edge_s) begin
                    state_nxt_s = HOLD;
                end else begin
                    state_nxt_s = XFER;
                end
            end
            HOLD: begin
                if (abort_s || finish_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Shift-register next values for transmit and receive.
    always_comb begin
        if (lsb_r) begin
            tx_next_s  = tx_shift_r >> 1'b1;
            next_bit_s = tx_next_s[0];
            rx_next_s  = rx_r | (DATA_W'(spi_i) << edge_cnt_r[EW-1:1]);
        end else begin
            tx_next_s  = tx_shift_r << 1'b1;
            next_bit_s = |(tx_next_s & (DATA_W'(1'b1) << (nbits_r - NB_ONE)));
            rx_next_s  = {rx_r[DATA_W-2:0], spi_i};
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath: config latch, divider, edge counter, shifters and pin registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q_r  <= 1'b0;
            abort_q_r  <= 1'b0;
            cpol_r     <= 1'b0;
            cpha_r     <= 1'b0;
            lsb_r      <= 1'b0;
            div_r      <= 8'd1;
            div_cnt_r  <= 8'd0;
            nbits_r    <= NBW'(DATA_W);
            edge_cnt_r <= {EW{1'b0}};
            tx_shift_r <= {DATA_W{1'b0}};
            rx_r       <= {DATA_W{1'b0}};
            data_rd_r  <= {DATA_W{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            spi_clk_r  <= 1'b0;
            spi_o_r    <= 1'b0;
            cs_n_r     <= {NUM_CS{1'b1}};
        end else begin
            start_q_r <= ctrl[1];
            abort_q_r <= ctrl[31];
            done_r    <= 1'b0;
            if (abort_s) begin
                cs_n_r    <= {NUM_CS{1'b1}};
                spi_clk_r <= cpol_r;
                busy_r    <= 1'b0;
            end else if (accept_s) begin
                cpol_r     <= ctrl[2];
                cpha_r     <= ctrl[3];
                lsb_r      <= ctrl[4];
                div_r      <= div_s;
                nbits_r    <= nbits_s;
                div_cnt_r  <= div_s - 8'd1;
                edge_cnt_r <= {EW{1'b0}};
                tx_shift_r <= src_s;
                rx_r       <= {DATA_W{1'b0}};
                spi_o_r    <= first_bit_s;
                spi_clk_r  <= ctrl[2];
                cs_n_r     <= ~cs_mask_s;
                busy_r     <= 1'b1;
            end else if (state_r == IDLE) begin
                spi_clk_r <= ctrl[2];
                if (ctrl[0]) begin
                    tx_shift_r <= data_tx;
                end
            end else if (finish_s) begin
                cs_n_r    <= {NUM_CS{1'b1}};
                data_rd_r <= rx_r;
                done_r    <= 1'b1;
                busy_r    <= 1'b0;
            end else if (edge_s) begin
                spi_clk_r  <= ~spi_clk_r;
                edge_cnt_r <= edge_cnt_r + EDGE_ONE;
                div_cnt_r  <= div_r - 8'd1;
                if (sample_s) begin
                    rx_r <= rx_next_s;
                end
                if (shift_s) begin
                    tx_shift_r <= tx_next_s;
                    spi_o_r    <= next_bit_s;
                end
            end else begin
                div_cnt_r <= div_cnt_r - 8'd1;
            end
        end
    end

    assign data_rd = data_rd_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign spi_clk = spi_clk_r;
    assign cs_n    = cs_n_r;
    assign spi_o   = spi_o_r;
endmodule

// File: tb/tb_spi_master_multi.sv
// Self-checking bench for spi_master_multi: random transfers against a bit-level
// reference of the SPI protocol, plus directed reset, drop, restart and abort cases.
module tb_spi_master_multi;
    localparam int DATA_W = 32;
    localparam int NUM_CS = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [31:0]       ctrl;
    logic [DATA_W-1:0] data_tx;
    logic [DATA_W-1:0] data_rd;
    logic              busy, done, spi_i, spi_clk, spi_o;
    logic [NUM_CS-1:0] cs_n;
    logic              lb, slave_bit;

    int checks   = 0;
    int failures = 0;

    assign spi_i = lb ? spi_o : slave_bit;

    always #5 clk = ~clk;

    spi_master_multi #(.DATA_W(DATA_W), .NUM_CS(NUM_CS)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ctrl    (ctrl),
        .data_tx (data_tx),
        .data_rd (data_rd),
        .busy    (busy),
        .done    (done),
        .spi_i   (spi_i),
        .spi_clk (spi_clk),
        .cs_n    (cs_n),
        .spi_o   (spi_o)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] cfg_word(input logic [7:0] divf, input logic [5:0] nbf,
                                             input logic [7:0] sel, input logic cpol,
                                             input logic cpha, input logic lsb);
        return {2'b00, nbf, sel, divf, 3'b000, lsb, cpha, cpol, 2'b00};
    endfunction

    task automatic check_reset_outputs();
        check_val("rst_spi_clk", 64'(spi_clk), 64'd0);
        check_val("rst_cs_n", 64'(cs_n), 64'(4'hF));
        check_val("rst_spi_o", 64'(spi_o), 64'd0);
        check_val("rst_data_rd", 64'(data_rd), 64'd0);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_done", 64'(done), 64'd0);
    endtask

    // mode: 0 normal, 1 second start while busy, 2 abort after 10 edges, 3 reset mid-transfer
    task automatic run_xfer(input logic [31:0] tx, input logic [31:0] miso, input int divf,
                            input int nbf, input int sel, input logic cpol, input logic cpha,
                            input logic lsb, input logic lbk, input int mode);
        int n, d, lat, edges, nsamp, cs_low, ndone, abort_cyc, done_cyc;
        logic saw_done, other_bad, prev_clk, leading;
        logic [63:0] mask, exp_rd, exp_mosi, got_mosi;
        logic [31:0] base, prev_rd;
        logic [NUM_CS-1:0] oh;
        n    = (nbf == 0 || nbf > DATA_W) ? DATA_W : nbf;
        d    = (divf == 0) ? 1 : divf;
        lat  = (2 * n + 1) * d;
        mask = (64'd1 << n) - 64'd1;
        exp_rd = (lbk ? {32'd0, tx} : {32'd0, miso}) & mask;
        exp_mosi = 64'd0;
        for (int k = 0; k < n; k++) exp_mosi[k] = lsb ? tx[k] : tx[n-1-k];
        oh   = NUM_CS'(1) << sel;
        base = cfg_word(8'(divf), 6'(nbf), 8'(sel), cpol, cpha, lsb);
        lb = lbk;
        slave_bit = lsb ? miso[0] : miso[n-1];
        @(negedge clk);
        ctrl = base | 32'h1;
        data_tx = tx;
        @(negedge clk);
        check_val("idle_clk", 64'(spi_clk), 64'(cpol));
        ctrl = base | 32'h2;
        prev_rd = data_rd;
        prev_clk = spi_clk;
        edges = 0; nsamp = 0; cs_low = 0; ndone = 0; abort_cyc = -1; done_cyc = 0;
        saw_done = 1'b0; other_bad = 1'b0; got_mosi = 64'd0;
        for (int cyc = 1; cyc <= lat + 20 + ((mode == 1) ? lat : 0); cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                ctrl = base;
                check_val("busy_start", 64'(busy), 64'd1);
            end
            if (mode == 1 && cyc == 4) ctrl = base | 32'h2;
            if (mode == 1 && cyc == 5) ctrl = base;
            if (mode == 3 && cyc == 20) begin
                rst_n = 1'b0;
                #1;
                check_reset_outputs();
                break;
            end
            if (spi_clk !== prev_clk) begin
                edges++;
                leading = (prev_clk === cpol);
                if (leading ^ cpha) begin
                    if (nsamp < 64) got_mosi[nsamp] = spi_o;
                    nsamp++;
                    if (nsamp < n) slave_bit = lsb ? miso[nsamp] : miso[n-1-nsamp];
                end
                prev_clk = spi_clk;
            end
            if (cs_n[sel] === 1'b0) cs_low++;
            if ((cs_n | oh) !== {NUM_CS{1'b1}}) other_bad = 1'b1;
            if (done === 1'b1) begin
                ndone++;
                if (!saw_done) begin
                    saw_done = 1'b1;
                    done_cyc = cyc;
                end
            end
            if (mode == 2) begin
                if (abort_cyc < 0 && edges == 10) begin
                    ctrl = base | 32'h8000_0000;
                    abort_cyc = cyc;
                end else if (abort_cyc >= 0 && cyc == abort_cyc + 1) begin
                    check_val("abort_cs_n", 64'(cs_n), 64'(4'hF));
                    check_val("abort_busy", 64'(busy), 64'd0);
                    check_val("abort_clk", 64'(spi_clk), 64'(cpol));
                    ctrl = base;
                end else if (abort_cyc >= 0 && cyc >= abort_cyc + lat) begin
                    break;
                end
            end else if (mode == 0 && saw_done) begin
                break;
            end else if (mode == 1 && saw_done && cyc >= done_cyc + lat) begin
                break;
            end
        end
        if (mode == 2) begin
            check_val("abort_hit", 64'(abort_cyc >= 0), 64'd1);
            check_val("abort_no_done", 64'(ndone), 64'd0);
            check_val("abort_data_rd", 64'(data_rd), 64'(prev_rd));
        end else if (mode != 3) begin
            check_val("done_seen", 64'(saw_done), 64'd1);
            check_val("latency", 64'(done_cyc), 64'(lat + 1));
            check_val("cs_low_cycles", 64'(cs_low), 64'(lat));
            check_val("spi_clk_edges", 64'(edges), 64'(2 * n));
            check_val("sample_count", 64'(nsamp), 64'(n));
            check_val("mosi_bits", got_mosi, exp_mosi);
            check_val("data_rd", 64'(data_rd), exp_rd);
            check_val("other_cs", 64'(other_bad), 64'd0);
            check_val("done_count", 64'(ndone), 64'd1);
            if (mode == 0) begin
                @(negedge clk);
                check_val("done_pulse", 64'(done), 64'd0);
                check_val("busy_end", 64'(busy), 64'd0);
                check_val("cs_n_end", 64'(cs_n), 64'(4'hF));
            end
        end
    endtask

    initial begin
        logic seen_busy, seen_done;
        rst_n = 1'b0;
        ctrl = 32'd0;
        data_tx = '0;
        lb = 1'b0;
        slave_bit = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs();

        // Legacy loopback, mode 0, divider and length default.
        run_xfer(32'h1234_5678, 32'h0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        // External slave, div 4, two words in turn.
        run_xfer(32'h1234_5678, 32'hCAFE_F00D, 4, 32, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        run_xfer(32'h8765_4321, 32'h0BAD_1DEA, 4, 32, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        // Mode 3, LSB-first, 8 bits.
        run_xfer(32'h0000_00A5, 32'h0, 2, 8, 0, 1'b1, 1'b1, 1'b1, 1'b1, 0);
        // Chip select 2 only.
        run_xfer(32'h0F0F_3C3C, 32'h5555_AAAA, 1, 16, 2, 1'b0, 1'b1, 1'b0, 1'b0, 0);

        // Out-of-range chip select is dropped.
        @(negedge clk);
        ctrl = cfg_word(8'd1, 6'd8, 8'd7, 1'b0, 1'b0, 1'b0) | 32'h2;
        seen_busy = 1'b0;
        seen_done = 1'b0;
        repeat (30) begin
            @(negedge clk);
            ctrl = cfg_word(8'd1, 6'd8, 8'd7, 1'b0, 1'b0, 1'b0);
            if (busy) seen_busy = 1'b1;
            if (done) seen_done = 1'b1;
        end
        check_val("drop_busy", 64'(seen_busy), 64'd0);
        check_val("drop_done", 64'(seen_done), 64'd0);

        // Abort and start edges together in IDLE: abort wins.
        @(negedge clk);
        ctrl = cfg_word(8'd1, 6'd8, 8'd0, 1'b0, 1'b0, 1'b0) | 32'h8000_0002;
        repeat (4) @(negedge clk);
        check_val("abort_start_busy", 64'(busy), 64'd0);
        ctrl = 32'd0;

        run_xfer(32'h1357_9BDF, 32'h2468_ACE0, 2, 16, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        run_xfer(32'hFFFF_0000, 32'hA5A5_5A5A, 2, 16, 3, 1'b1, 1'b0, 1'b0, 1'b0, 2);

        for (int i = 0; i < 30; i++) begin
            run_xfer($urandom, $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 40)),
                     int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 1'($urandom),
                     1'($urandom), 0);
        end

        // Reset mid-transfer, then a fresh loopback word.
        run_xfer(32'h89AB_CDEF, 32'h0, 1, 32, 0, 1'b0, 1'b0, 1'b0, 1'b1, 3);
        ctrl = 32'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_xfer(32'hDEAD_BEEF, 32'h0, 1, 32, 0, 1'b0, 1'b0, 1'b0, 1'b1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
